mcu_rst_ctrl: RTL and testbench
===============================

Name: mcu_rst_ctrl

Overview:
Reset request controller in front of mcu_reset. It collects soft-reset requests from the E902 core, watchdog, debugger and a keyed software register, and arbitrates them. It drives a clean, fixed-width soft_rst_out[1:0] into mcu_reset's cpu_pad_soft_rst input. It runs on the POR-derived reset, so it survives the core and system resets it triggers and keeps a sticky reset-cause record.

Parameters:
HOLD_CYC, 4, cycles soft_rst_out is held high; legal range 3..255, since mcu_reset needs ≥2 stable cycles.
GUARD_CYC, 8, cycles after release during which new launches are blocked; legal range 1..255.
CNT_W, 8, counter width; must hold max(HOLD_CYC, GUARD_CYC)-1.

Ports:
sys_clk  in  1  system clock
mcu_rstn  in  1  asynchronous active-low reset; mcu_reset's synchronized POR, also driven to pad_had_jtg_trst_b
cpu_soft_rst_req  in  2  core soft-reset levels; bit0 = core, bit1 = system
wdt_rst_req  in  1  watchdog timeout level; system class
dbg_core_rst_req  in  1  debugger request level; core class
reg_sel  in  1  register access strobe
reg_wr  in  1  1 = write, 0 = read
reg_addr  in  1  0 = CTRL, 1 = CAUSE
reg_wdata  in  32  write data
reg_rdata  out  32  read data; combinational, valid when reg_sel=1
soft_rst_out  out  2  to mcu_reset cpu_pad_soft_rst; bit0 = core, bit1 = system
rst_busy  out  1  high while in ASSERT_* or GUARD

Behaviour:
- Reset (mcu_rstn=0, asynchronous): state IDLE; soft_rst_out=2'b00; rst_busy=0; counter=0; pending=0; CAUSE=0; edge-detect history flops=0.
- Edge detection: all four request inputs are levels. Only the rising edge (in=1, prev=0) is an event, so a stuck-high level fires once.
- A level already high at reset release counts as an edge on the first clock.
- Software events: a write (reg_sel & reg_wr) to addr 0 with wdata[15:8]==8'h5A:
  - wdata[0] is a sw-core event; wdata[1] is a sw-sys event.
  - A wrong key sets CAUSE[7] and causes no event.
- Pending flags:
  - sys_pend is set by cpu_soft_rst_req[1], wdt or sw-sys events.
  - core_pend is set by cpu_soft_rst_req[0], dbg or sw-core events.
  - Events are latched in any state, including ASSERT and GUARD.
- FSM states: IDLE, ASSERT_CORE, ASSERT_SYS, GUARD.
  - IDLE: if sys_pend, go to ASSERT_SYS and clear both sys_pend and core_pend (system reset subsumes core). Else if core_pend, go to ASSERT_CORE and clear core_pend. The counter loads HOLD_CYC-1.
  - ASSERT_*: decrement each cycle; at 0, go to GUARD and load GUARD_CYC-1.
  - GUARD: decrement; at 0, go to IDLE.
  - No preemption: a sys event during ASSERT_CORE waits as pending and launches after GUARD.
- Outputs are registered decodes of the next state: soft_rst_out[1]=ASSERT_SYS, soft_rst_out[0]=ASSERT_CORE, rst_busy=(state!=IDLE). The two soft_rst_out bits are never high together.
- Latency: an input edge sampled at clock edge E sets pending at E. soft_rst_out rises at E+1 when IDLE. It stays high for exactly HOLD_CYC cycles, then rst_busy stays high for GUARD_CYC further cycles.
- CAUSE register (addr 1), sticky bits:
  - [0] cpu core, [1] cpu sys, [2] wdt, [3] dbg, [4] sw core, [5] sw sys, [7] key error.
  - Bits are set on the corresponding event.
  - Write-1-to-clear; a set and a clear in the same cycle leaves the bit set.
  - CAUSE is cleared only by mcu_rstn.
- Reads:
  - addr 0 returns {29'b0, rst_busy, soft_rst_out}.
  - addr 1 returns {24'b0, CAUSE}.
  - reg_rdata=0 when reg_sel=0.
- Reset mid-operation: mcu_rstn low in any state drops soft_rst_out immediately (asynchronously) and discards pending requests.

Decomposition:
- Package mcu_rst_pkg holds:
  - FSM state enum;
  - register address constants (CTRL=0, CAUSE=1);
  - KEY=8'h5A;
  - CAUSE bit index constants.
- One sub-module, mcu_rst_edge: a parameterised-width rising-edge detector, instanced once for the 4 request levels.
- FSM, counter, pending flags and register file live in mcu_rst_ctrl.

Test Plan:
1. Release mcu_rstn, all inputs 0 -> soft_rst_out=00, rst_busy=0, CAUSE reads 0x00, with no activity for 50 cycles.
2. cpu_soft_rst_req[0] goes high and stays high -> soft_rst_out=01 for exactly 4 cycles starting 1 cycle after the sampling edge, then rst_busy for 8 more cycles, then IDLE; no retrigger while the level stays high; CAUSE=0x01.
3. wdt_rst_req and dbg_core_rst_req rise in the same cycle -> only soft_rst_out=10 for 4 cycles, core request absorbed, no follow-up core pulse; CAUSE=0x0C.
4. dbg edge, then a CTRL write 0x00005A02 during ASSERT_CORE -> core pulse completes, then after 8 guard cycles soft_rst_out=10 for 4 cycles; CAUSE=0x28.
5. CTRL write 0x00003301 -> no pulse, CAUSE[7]=1; write 0x80 to CAUSE -> reads 0x00; a W1C coinciding with a new wdt edge leaves CAUSE[2]=1.
6. Drop mcu_rstn during the second ASSERT_SYS cycle with core_pend set -> soft_rst_out=00 immediately; after release IDLE, no pulse, CAUSE=0.

Source files
------------

// File: rtl/mcu_rst_pkg.sv
// mcu_rst_pkg: shared states, register map, key and cause-bit positions for the reset controller
package mcu_rst_pkg;
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ASSERT_CORE,
    ST_ASSERT_SYS,
    ST_GUARD
  } state_e;
  localparam logic ADDR_CTRL = 1'b0;
  localparam logic ADDR_CAUSE = 1'b1;
  localparam logic [7:0] KEY = 8'h5A;
  localparam int unsigned CB_CPU_CORE = 0;
  localparam int unsigned CB_CPU_SYS = 1;
  localparam int unsigned CB_WDT = 2;
  localparam int unsigned CB_DBG = 3;
  localparam int unsigned CB_SW_CORE = 4;
  localparam int unsigned CB_SW_SYS = 5;
  localparam int unsigned CB_KEY_ERR = 7;
endpackage

// File: rtl/mcu_rst_edge.sv
// mcu_rst_edge: rising-edge detector over a vector of levels; history clears on reset so a level high at release fires once
module mcu_rst_edge #(
  parameter int unsigned W = 4
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic [W-1:0] lvl_i,
  output logic [W-1:0] rise_o
);
  logic [W-1:0] prev_q;
  assign rise_o = lvl_i & ~prev_q;
  // remember last sampled level
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) prev_q <= '0;
    else prev_q <= lvl_i;
  end
endmodule

// File: rtl/mcu_rst_ctrl.sv
// mcu_rst_ctrl: collects soft-reset requests, arbitrates system over core, and emits fixed-width pulses with a guard gap
module mcu_rst_ctrl import mcu_rst_pkg::*; #(
  parameter int unsigned HOLD_CYC = 4,
  parameter int unsigned GUARD_CYC = 8,
  parameter int unsigned CNT_W = 8
) (
  input  logic        sys_clk,
  input  logic        mcu_rstn,
  input  logic [1:0]  cpu_soft_rst_req,
  input  logic        wdt_rst_req,
  input  logic        dbg_core_rst_req,
  input  logic        reg_sel,
  input  logic        reg_wr,
  input  logic        reg_addr,
  input  logic [31:0] reg_wdata,
  output logic [31:0] reg_rdata,
  output logic [1:0]  soft_rst_out,
  output logic        rst_busy
);
  logic [3:0] rise;
  state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic sys_pend_q, sys_pend_d, core_pend_q, core_pend_d;
  logic clr_sys, clr_core;
  logic [7:0] cause_q, cause_d, cause_set, cause_clr;
  logic [1:0] soft_q;
  logic busy_q;
  logic wr_ctrl, wr_cause, key_ok, sw_core, sw_sys, sys_ev, core_ev;
  logic unused_wdata;

  mcu_rst_edge #(.W(4)) u_edge (
    .clk_i (sys_clk),
    .rst_ni(mcu_rstn),
    .lvl_i ({dbg_core_rst_req, wdt_rst_req, cpu_soft_rst_req}),
    .rise_o(rise)
  );

  assign unused_wdata = ^reg_wdata[31:16];
  assign wr_ctrl = reg_sel & reg_wr & (reg_addr == ADDR_CTRL);
  assign wr_cause = reg_sel & reg_wr & (reg_addr == ADDR_CAUSE);
  assign key_ok = reg_wdata[15:8] == KEY;
  assign sw_core = wr_ctrl & key_ok & reg_wdata[0];
  assign sw_sys = wr_ctrl & key_ok & reg_wdata[1];
  assign sys_ev = rise[1] | rise[2] | sw_sys;
  assign core_ev = rise[0] | rise[3] | sw_core;
  assign soft_rst_out = soft_q;
  assign rst_busy = busy_q;
  assign reg_rdata = !reg_sel ? 32'h0 :
                     (reg_addr == ADDR_CAUSE) ? {24'h0, cause_q} : {29'h0, busy_q, soft_q};

  // launch arbitration (system subsumes core) and hold/guard countdown
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    clr_sys = 1'b0;
    clr_core = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (sys_pend_q) begin
          state_d = ST_ASSERT_SYS;
          clr_sys = 1'b1;
          clr_core = 1'b1;
          cnt_d = CNT_W'(HOLD_CYC - 1);
        end else if (core_pend_q) begin
          state_d = ST_ASSERT_CORE;
          clr_core = 1'b1;
          cnt_d = CNT_W'(HOLD_CYC - 1);
        end
      end
      ST_ASSERT_CORE, ST_ASSERT_SYS: begin
        state_d = (cnt_q == '0) ? ST_GUARD : state_q;
        cnt_d = (cnt_q == '0) ? CNT_W'(GUARD_CYC - 1) : cnt_q - 1'b1;
      end
      ST_GUARD: begin
        state_d = (cnt_q == '0) ? ST_IDLE : ST_GUARD;
        cnt_d = (cnt_q == '0) ? cnt_q : cnt_q - 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // pending flags latch in every state; sticky cause with set winning over W1C
  always_comb begin
    sys_pend_d = (sys_pend_q & ~clr_sys) | sys_ev;
    core_pend_d = (core_pend_q & ~clr_core) | core_ev;
    cause_set = '0;
    cause_set[CB_CPU_CORE] = rise[0];
    cause_set[CB_CPU_SYS] = rise[1];
    cause_set[CB_WDT] = rise[2];
    cause_set[CB_DBG] = rise[3];
    cause_set[CB_SW_CORE] = sw_core;
    cause_set[CB_SW_SYS] = sw_sys;
    cause_set[CB_KEY_ERR] = wr_ctrl & ~key_ok;
    cause_clr = wr_cause ? reg_wdata[7:0] : 8'h00;
    cause_d = (cause_q & ~cause_clr) | cause_set;
  end

  // state, counter, flags, cause and registered output decode of the next state
  always_ff @(posedge sys_clk or negedge mcu_rstn) begin
    if (!mcu_rstn) begin
      state_q <= ST_IDLE;
      cnt_q <= '0;
      sys_pend_q <= 1'b0;
      core_pend_q <= 1'b0;
      cause_q <= '0;
      soft_q <= 2'b00;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      sys_pend_q <= sys_pend_d;
      core_pend_q <= core_pend_d;
      cause_q <= cause_d;
      soft_q <= {state_d == ST_ASSERT_SYS, state_d == ST_ASSERT_CORE};
      busy_q <= state_d != ST_IDLE;
    end
  end
endmodule

// File: tb/tb_mcu_rst_ctrl.sv
// tb_mcu_rst_ctrl: directed scenarios plus randomized traffic against a timeline-based reference model
module tb_mcu_rst_ctrl;
  localparam int HOLD = 4;
  localparam int GUARD = 8;
  logic sys_clk = 1'b0;
  logic mcu_rstn = 1'b1;
  logic [1:0] cpu_soft_rst_req = 2'b00;
  logic wdt_rst_req = 1'b0;
  logic dbg_core_rst_req = 1'b0;
  logic reg_sel = 1'b0;
  logic reg_wr = 1'b0;
  logic reg_addr = 1'b0;
  logic [31:0] reg_wdata = 32'h0;
  logic [31:0] reg_rdata;
  logic [1:0] soft_rst_out;
  logic rst_busy;
  int errors = 0;
  int checks = 0;

  int m_t = -1;
  logic [1:0] m_kind = 2'b00;
  logic m_sp = 1'b0, m_cp = 1'b0;
  logic [7:0] m_cause = 8'h00;
  logic [3:0] m_prev = 4'h0;

  mcu_rst_ctrl #(.HOLD_CYC(HOLD), .GUARD_CYC(GUARD), .CNT_W(8)) dut (
    .sys_clk(sys_clk), .mcu_rstn(mcu_rstn), .cpu_soft_rst_req(cpu_soft_rst_req),
    .wdt_rst_req(wdt_rst_req), .dbg_core_rst_req(dbg_core_rst_req),
    .reg_sel(reg_sel), .reg_wr(reg_wr), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
    .reg_rdata(reg_rdata), .soft_rst_out(soft_rst_out), .rst_busy(rst_busy)
  );

  always #5 sys_clk = ~sys_clk;

  // reference: a launch starts a timeline t = 0..HOLD+GUARD-1, first HOLD steps pulse, then guard
  always @(posedge sys_clk or negedge mcu_rstn) begin
    logic [3:0] lv, rs;
    logic wc, good, swc, sws;
    logic [7:0] clr;
    if (!mcu_rstn) begin
      m_t = -1; m_kind = 2'b00; m_sp = 1'b0; m_cp = 1'b0; m_cause = 8'h00; m_prev = 4'h0;
    end else begin
      lv = {dbg_core_rst_req, wdt_rst_req, cpu_soft_rst_req};
      rs = lv & ~m_prev;
      m_prev = lv;
      wc = reg_sel && reg_wr && (reg_addr == 1'b0);
      good = reg_wdata[15:8] == 8'h5A;
      swc = wc && good && reg_wdata[0];
      sws = wc && good && reg_wdata[1];
      clr = (reg_sel && reg_wr && reg_addr) ? reg_wdata[7:0] : 8'h00;
      m_cause = (m_cause & ~clr) | {wc && !good, 1'b0, sws, swc, rs};
      if (m_t < 0) begin
        if (m_sp) begin m_kind = 2'b10; m_t = 0; m_sp = 1'b0; m_cp = 1'b0; end
        else if (m_cp) begin m_kind = 2'b01; m_t = 0; m_cp = 1'b0; end
      end else begin
        m_t++;
        if (m_t == HOLD + GUARD) m_t = -1;
      end
      m_sp = m_sp | rs[1] | rs[2] | sws;
      m_cp = m_cp | rs[0] | rs[3] | swc;
    end
  end

  function automatic logic [1:0] m_out();
    return (m_t >= 0 && m_t < HOLD) ? m_kind : 2'b00;
  endfunction

  task automatic reg_write(input logic a, input logic [31:0] d);
    reg_sel = 1'b1; reg_wr = 1'b1; reg_addr = a; reg_wdata = d;
    @(negedge sys_clk);
    reg_sel = 1'b0; reg_wr = 1'b0;
  endtask

  task automatic test_reset();
    #1 mcu_rstn = 1'b0;
    #1;
    checks++;
    if (soft_rst_out !== 2'b00 || rst_busy !== 1'b0) begin
      errors++; $display("FAIL reset_hold got=%b/%b exp=00/0", soft_rst_out, rst_busy);
    end
    repeat (3) @(negedge sys_clk);
    mcu_rstn = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge sys_clk);
      checks++;
      if (soft_rst_out !== 2'b00 || rst_busy !== 1'b0) begin
        errors++; $display("FAIL idle_after_reset cyc=%0d got=%b/%b exp=00/0", i, soft_rst_out, rst_busy);
      end
    end
    reg_sel = 1'b1; reg_wr = 1'b0; reg_addr = 1'b1; #1;
    checks++;
    if (reg_rdata !== 32'h0) begin errors++; $display("FAIL cause_reset got=%h exp=0", reg_rdata); end
    reg_sel = 1'b0;
  endtask

  task automatic test_core_level();
    cpu_soft_rst_req[0] = 1'b1;
    for (int i = 0; i < 24; i++) begin
      @(negedge sys_clk);
      checks++;
      if (soft_rst_out !== ((i >= 1 && i <= HOLD) ? 2'b01 : 2'b00) || rst_busy !== (i >= 1 && i <= HOLD + GUARD)) begin
        errors++; $display("FAIL core_pulse cyc=%0d got=%b/%b", i, soft_rst_out, rst_busy);
      end
    end
    cpu_soft_rst_req[0] = 1'b0;
    reg_sel = 1'b1; reg_wr = 1'b0; reg_addr = 1'b1; #1;
    checks++;
    if (reg_rdata !== 32'h01) begin errors++; $display("FAIL cause_core got=%h exp=01", reg_rdata); end
    @(negedge sys_clk);
    reg_write(1'b1, 32'hFF);
  endtask

  task automatic test_sys_absorbs_core();
    wdt_rst_req = 1'b1; dbg_core_rst_req = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge sys_clk);
      checks++;
      if (soft_rst_out !== ((i >= 1 && i <= HOLD) ? 2'b10 : 2'b00) || rst_busy !== (i >= 1 && i <= HOLD + GUARD)) begin
        errors++; $display("FAIL sys_absorb cyc=%0d got=%b/%b", i, soft_rst_out, rst_busy);
      end
    end
    wdt_rst_req = 1'b0; dbg_core_rst_req = 1'b0;
    reg_sel = 1'b1; reg_wr = 1'b0; reg_addr = 1'b1; #1;
    checks++;
    if (reg_rdata !== 32'h0C) begin errors++; $display("FAIL cause_absorb got=%h exp=0c", reg_rdata); end
    @(negedge sys_clk);
    reg_write(1'b1, 32'hFF);
  endtask

  task automatic test_back_to_back();
    logic [1:0] eo;
    dbg_core_rst_req = 1'b1;
    for (int i = 0; i < 32; i++) begin
      @(negedge sys_clk);
      reg_sel = 1'b0; reg_wr = 1'b0;
      eo = (i >= 1 && i <= 4) ? 2'b01 : (i >= 14 && i <= 17) ? 2'b10 : 2'b00;
      checks++;
      if (soft_rst_out !== eo || rst_busy !== ((i >= 1 && i <= 12) || (i >= 14 && i <= 25))) begin
        errors++; $display("FAIL back_to_back cyc=%0d got=%b/%b exp=%b", i, soft_rst_out, rst_busy, eo);
      end
      if (i == 2) begin reg_sel = 1'b1; reg_wr = 1'b1; reg_addr = 1'b0; reg_wdata = 32'h0000_5A02; end
    end
    dbg_core_rst_req = 1'b0;
    reg_sel = 1'b1; reg_wr = 1'b0; reg_addr = 1'b1; #1;
    checks++;
    if (reg_rdata !== 32'h28) begin errors++; $display("FAIL cause_b2b got=%h exp=28", reg_rdata); end
    @(negedge sys_clk);
    reg_write(1'b1, 32'hFF);
  endtask

  task automatic test_key_and_w1c();
    reg_write(1'b0, 32'h0000_3301);
    for (int i = 0; i < 10; i++) begin
      @(negedge sys_clk);
      checks++;
      if (soft_rst_out !== 2'b00 || rst_busy !== 1'b0) begin
        errors++; $display("FAIL bad_key_pulse cyc=%0d got=%b/%b exp=00/0", i, soft_rst_out, rst_busy);
      end
    end
    reg_sel = 1'b1; reg_wr = 1'b0; reg_addr = 1'b1; #1;
    checks++;
    if (reg_rdata !== 32'h80) begin errors++; $display("FAIL cause_key got=%h exp=80", reg_rdata); end
    @(negedge sys_clk);
    reg_write(1'b1, 32'h80);
    reg_sel = 1'b1; reg_wr = 1'b0; reg_addr = 1'b1; #1;
    checks++;
    if (reg_rdata !== 32'h00) begin errors++; $display("FAIL cause_w1c got=%h exp=00", reg_rdata); end
    @(negedge sys_clk);
    wdt_rst_req = 1'b1;
    reg_write(1'b1, 32'h04);
    reg_sel = 1'b1; reg_wr = 1'b0; reg_addr = 1'b1; #1;
    checks++;
    if (reg_rdata !== 32'h04) begin errors++; $display("FAIL cause_set_wins got=%h exp=04", reg_rdata); end
    reg_sel = 1'b0;
    repeat (20) @(negedge sys_clk);
    wdt_rst_req = 1'b0;
    reg_write(1'b1, 32'hFF);
  endtask

  task automatic test_reset_mid();
    wdt_rst_req = 1'b1;
    @(negedge sys_clk);
    @(negedge sys_clk);
    dbg_core_rst_req = 1'b1;
    @(negedge sys_clk);
    checks++;
    if (soft_rst_out !== 2'b10) begin errors++; $display("FAIL mid_pre got=%b exp=10", soft_rst_out); end
    #2 mcu_rstn = 1'b0;
    #1;
    checks++;
    if (soft_rst_out !== 2'b00 || rst_busy !== 1'b0) begin
      errors++; $display("FAIL mid_async_drop got=%b/%b exp=00/0", soft_rst_out, rst_busy);
    end
    wdt_rst_req = 1'b0; dbg_core_rst_req = 1'b0;
    @(negedge sys_clk);
    mcu_rstn = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge sys_clk);
      checks++;
      if (soft_rst_out !== 2'b00 || rst_busy !== 1'b0) begin
        errors++; $display("FAIL mid_after cyc=%0d got=%b/%b exp=00/0", i, soft_rst_out, rst_busy);
      end
    end
    reg_sel = 1'b1; reg_wr = 1'b0; reg_addr = 1'b1; #1;
    checks++;
    if (reg_rdata !== 32'h00) begin errors++; $display("FAIL cause_mid got=%h exp=00", reg_rdata); end
    reg_sel = 1'b0;
  endtask

  task automatic test_random();
    logic [31:0] exp;
    int op;
    for (int i = 0; i < 3000; i++) begin
      @(negedge sys_clk);
      checks++;
      if (soft_rst_out !== m_out() || rst_busy !== (m_t >= 0)) begin
        errors++; $display("FAIL rand_out cyc=%0d got=%b/%b exp=%b/%b", i, soft_rst_out, rst_busy, m_out(), m_t >= 0);
      end
      if ($urandom_range(0, 15) == 0) cpu_soft_rst_req[0] = ~cpu_soft_rst_req[0];
      if ($urandom_range(0, 15) == 0) cpu_soft_rst_req[1] = ~cpu_soft_rst_req[1];
      if ($urandom_range(0, 15) == 0) wdt_rst_req = ~wdt_rst_req;
      if ($urandom_range(0, 15) == 0) dbg_core_rst_req = ~dbg_core_rst_req;
      op = int'($urandom_range(0, 15));
      reg_sel = op < 5; reg_wr = op < 2; reg_addr = op[0];
      reg_wdata = op == 0 ? {16'h0, ($urandom_range(0, 3) != 0) ? 8'h5A : 8'(32'($urandom)), 6'h0, 2'($urandom)} :
                  {24'h0, 8'(32'($urandom))};
      if (op >= 2) begin
        exp = op >= 5 ? 32'h0 : op == 3 ? {24'h0, m_cause} : {29'h0, m_t >= 0, m_out()};
        #1;
        checks++;
        if (reg_rdata !== exp) begin
          errors++; $display("FAIL rand_read cyc=%0d op=%0d got=%h exp=%h", i, op, reg_rdata, exp);
        end
      end
    end
    reg_sel = 1'b0; reg_wr = 1'b0;
  endtask

  initial begin
    test_reset();
    test_core_level();
    test_sys_absorbs_core();
    test_back_to_back();
    test_key_and_w1c();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
